ql_mult_x2_accum: RTL and testbench
===================================

Name: ql_mult_x2_accum

Overview:
- Accumulator stage directly downstream of the dual 16x16 multiplier wrapper (two independent lanes, Cmult1/Cmult2 with Valid_mult1/Valid_mult2).
- Registers each lane's 32-bit product, sums a programmable number of products into a wide saturating accumulator, and presents one dot-product result per lane per accumulation window.
- Turns the combinational multiplier hard macro into a pipelined dual MAC for FIR/dot-product fabric logic.

Parameters:
- ACC_W, 40, accumulator/result width in bits; legal range 33..64.
- CNT_W, 8, width of the window-length input; maximum window is 2^CNT_W-1 products.
- SIGNED, 1, 1 = Cmult inputs are two's-complement and sign-extended; 0 = unsigned and zero-extended.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all lane state.
- len  input  CNT_W  number of products per accumulation window, shared by both lanes.
- Cmult1  input  32  lane-1 product.
- Valid_mult1  input  1  Cmult1 is valid this cycle.
- Cmult2  input  32  lane-2 product.
- Valid_mult2  input  1  Cmult2 is valid this cycle.
- Acc1  output  ACC_W  lane-1 completed accumulation.
- Acc1_valid  output  1  one-cycle pulse; Acc1 is new.
- Ovf1  output  1  lane-1 window saturated; qualified by Acc1_valid.
- Acc2, Acc2_valid, Ovf2  output  ACC_W,1,1  lane-2 equivalents.
- busy  output  1  either lane has a partial window in progress or a product in its pipeline register.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers are 0, including Acc*, Acc*_valid, Ovf*, busy, accumulators, counters and pipeline valids.
- Lanes are fully independent. Lane 2 mirrors lane 1 exactly; only lane 1 is described below.
- Stage 1 (product register):
  - On the edge where Valid_mult1=1, Cmult1 is captured, extended to ACC_W bits per SIGNED, and the pipeline valid p1v is set to 1.
  - Otherwise p1v is 0.
- Stage 2 (accumulate), on each edge with p1v=1:
  - If cnt1==0 (start of window): acc1 <= product; cnt1 <= 1; win1 <= max(len,1). len is captured only here, so changing len mid-window does not affect the window in progress.
  - Otherwise: acc1 <= sat(acc1+product); cnt1 <= cnt1+1.
  - Saturation: the sum is formed at ACC_W+1 bits.
    - SIGNED=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
    - SIGNED=0: clamp to 2^ACC_W-1.
  - Any clamp sets ovf1, which stays set until the window ends. Accumulation continues from the clamped value.
- Window completion: on the stage-2 edge where the updated count equals win1:
  - Acc1 <= final sum; Ovf1 <= ovf1 OR the clamp on this edge; Acc1_valid <= 1 for exactly one cycle.
  - cnt1 <= 0 and ovf1 <= 0.
  - Acc1 and Ovf1 hold their values until the next completion.
- Latency: Cmult1 sampled at edge E0 feeds stage 2 at E1. For the last product of a window, Acc1/Acc1_valid update at E1, i.e. they are visible 1 cycle after the sampling edge.
- Throughput: one product per lane per cycle, with no bubbles between back-to-back windows. The first product of the next window may enter stage 2 on the edge immediately after completion.
- Gaps: Valid_mult1 may deassert for any number of cycles mid-window; the partial state is held.
- clr=1 at an edge:
  - Clears p1v, acc, cnt, ovf and Acc*_valid in both lanes.
  - Leaves Acc*/Ovf* data values unchanged.
  - Overrides a simultaneous Valid_mult input; that product is dropped.
  - A completion that would have occurred on the same edge is suppressed.
- Reset mid-window discards all partial state immediately. The first product after release starts a new window.
- busy = p1v1 | p1v2 | (cnt1!=0) | (cnt2!=0).

Test Plan:
1. Lane 1, len=4, SIGNED=1, Cmult1 = 10, 20, 30, 40 on consecutive cycles -> single Acc1_valid pulse one cycle after the 4th sample edge, Acc1=100, Ovf1=0; Acc2_valid stays 0.
2. len=1, Cmult1 = 0xFFFFFFFF then 5 on consecutive cycles -> two consecutive Acc1_valid pulses, Acc1=-1 (all ones, ACC_W bits) then 5. Repeat with len=0 -> identical response.
3. ACC_W=33, SIGNED=1, len=3, Cmult1 = 0x7FFFFFFF three times -> Acc1=0x0FFFFFFFF (2^32-1, clamped), Ovf1=1. The next window of len=1 with value 1 -> Acc1=1, Ovf1=0.
4. Both lanes, len=3. Lane 1 gets 1, 2, 3 back-to-back. Lane 2 gets 7, idle 2 cycles, 7, idle, 7 -> Acc1=6 and Acc2=21, each pulsing one cycle after its own last sample; len changed to 5 after lane 2's first sample does not alter lane 2's result.
5. len=4, two products accepted, then clr=1 coinciding with Valid_mult1=1 -> no Acc1_valid, busy=0 the cycle after clr, prior Acc1 value retained. A fresh 4-product window then completes correctly.
6. rst_n pulsed low asynchronously between clock edges mid-window -> all outputs 0 immediately. After release, a len=2 window of 3, 4 -> Acc1=7.

Source files
------------

// File: rtl/ql_mult_x2_accum.sv
// Dual-lane pipelined MAC behind the 16x16 multiplier pair: registers each
// lane's product, accumulates windows of len products with saturation.

module ql_mult_x2_accum_lane #(
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      cmult,
  input  logic             valid_mult,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             ovf_out,
  output logic             busy
);

  localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] U_MAX   = {ACC_W{1'b1}};

  logic             p_v_q, p_v_d;
  logic [ACC_W-1:0] p_q, p_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             res_ovf_q, res_ovf_d;

  logic             ext_sign;
  logic [ACC_W-1:0] product_ext;
  logic             acc_sign;
  logic             p_sign;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_sat;
  logic             clamp;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] win_eff;
  logic             done;

  // Product extension and the ACC_W+1 bit saturating sum of acc and product.
  always_comb begin
    ext_sign    = (SIGNED != 0) ? cmult[31] : 1'b0;
    product_ext = {{(ACC_W-32){ext_sign}}, cmult};
    acc_sign    = (SIGNED != 0) ? acc_q[ACC_W-1] : 1'b0;
    p_sign      = (SIGNED != 0) ? p_q[ACC_W-1] : 1'b0;
    sum_wide    = {acc_sign, acc_q} + {p_sign, p_q};
    if (SIGNED != 0) begin
      clamp   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      sum_sat = clamp ? (sum_wide[ACC_W] ? NEG_MIN : POS_MAX) : sum_wide[ACC_W-1:0];
    end else begin
      clamp   = sum_wide[ACC_W];
      sum_sat = clamp ? U_MAX : sum_wide[ACC_W-1:0];
    end
    cnt_inc = cnt_q + CNT_W'(1);
    win_eff = (len == '0) ? CNT_W'(1) : len;
  end

  always_comb begin
    p_v_d       = valid_mult & ~clr;
    p_d         = valid_mult ? product_ext : p_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = 1'b0;
    done        = 1'b0;

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (p_v_q) begin
      if (cnt_q == '0) begin
        acc_d = p_q;
        cnt_d = CNT_W'(1);
        win_d = win_eff;
        done  = (win_eff == CNT_W'(1));
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | clamp;
        done  = (cnt_inc == win_q);
      end
      // Window end: publish, then free the lane for a bubble-free next window.
      if (done) begin
        res_d       = acc_d;
        res_ovf_d   = ovf_d;
        res_valid_d = 1'b1;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v_q       <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      win_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      p_v_q       <= p_v_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign acc_out   = res_q;
  assign acc_valid = res_valid_q;
  assign ovf_out   = res_ovf_q;
  assign busy      = p_v_q | (cnt_q != '0);

endmodule

module ql_mult_x2_accum #(
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      Cmult1,
  input  logic             Valid_mult1,
  input  logic [31:0]      Cmult2,
  input  logic             Valid_mult2,
  output logic [ACC_W-1:0] Acc1,
  output logic             Acc1_valid,
  output logic             Ovf1,
  output logic [ACC_W-1:0] Acc2,
  output logic             Acc2_valid,
  output logic             Ovf2,
  output logic             busy
);

  logic busy1;
  logic busy2;

  ql_mult_x2_accum_lane #(.ACC_W(ACC_W), .CNT_W(CNT_W), .SIGNED(SIGNED)) u_lane1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .len        (len),
    .cmult      (Cmult1),
    .valid_mult (Valid_mult1),
    .acc_out    (Acc1),
    .acc_valid  (Acc1_valid),
    .ovf_out    (Ovf1),
    .busy       (busy1)
  );

  ql_mult_x2_accum_lane #(.ACC_W(ACC_W), .CNT_W(CNT_W), .SIGNED(SIGNED)) u_lane2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .len        (len),
    .cmult      (Cmult2),
    .valid_mult (Valid_mult2),
    .acc_out    (Acc2),
    .acc_valid  (Acc2_valid),
    .ovf_out    (Ovf2),
    .busy       (busy2)
  );

  assign busy = busy1 | busy2;

endmodule

// File: tb/tb_ql_mult_x2_accum.sv
// Bench for ql_mult_x2_accum: three configurations share one stimulus stream
// and are checked every cycle against a window-level arithmetic model.

module tb_ql_mult_x2_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [31:0] c1 = '0;
  logic        v1 = 1'b0;
  logic [31:0] c2 = '0;
  logic        v2 = 1'b0;

  logic [39:0] a_acc1, a_acc2;
  logic        a_v1, a_v2, a_o1, a_o2, a_busy;
  logic [32:0] b_acc1, b_acc2;
  logic        b_v1, b_v2, b_o1, b_o2, b_busy;
  logic [32:0] c_acc1, c_acc2;
  logic        c_v1, c_v2, c_o1, c_o2, c_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ql_mult_x2_accum #(.ACC_W(40), .CNT_W(8), .SIGNED(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .len(len),
    .Cmult1(c1), .Valid_mult1(v1), .Cmult2(c2), .Valid_mult2(v2),
    .Acc1(a_acc1), .Acc1_valid(a_v1), .Ovf1(a_o1),
    .Acc2(a_acc2), .Acc2_valid(a_v2), .Ovf2(a_o2), .busy(a_busy)
  );

  ql_mult_x2_accum #(.ACC_W(33), .CNT_W(8), .SIGNED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .len(len),
    .Cmult1(c1), .Valid_mult1(v1), .Cmult2(c2), .Valid_mult2(v2),
    .Acc1(b_acc1), .Acc1_valid(b_v1), .Ovf1(b_o1),
    .Acc2(b_acc2), .Acc2_valid(b_v2), .Ovf2(b_o2), .busy(b_busy)
  );

  ql_mult_x2_accum #(.ACC_W(33), .CNT_W(8), .SIGNED(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .len(len),
    .Cmult1(c1), .Valid_mult1(v1), .Cmult2(c2), .Valid_mult2(v2),
    .Acc1(c_acc1), .Acc1_valid(c_v1), .Ovf1(c_o1),
    .Acc2(c_acc2), .Acc2_valid(c_v2), .Ovf2(c_o2), .busy(c_busy)
  );

  // Model state per configuration (a,b,c) and lane: the product waiting one
  // cycle, the running window as a plain integer, and the last published result.
  int                  cfg_w [3] = '{40, 33, 33};
  bit                  cfg_s [3] = '{1'b1, 1'b1, 1'b0};
  bit                  m_pv    [3][2];
  logic signed [127:0] m_pval  [3][2];
  logic signed [127:0] m_sum   [3][2];
  int                  m_cnt   [3][2];
  int                  m_win   [3][2];
  bit                  m_ovf   [3][2];
  logic signed [127:0] m_racc  [3][2];
  bit                  m_rvalid[3][2];
  bit                  m_rovf  [3][2];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [127:0] extendProduct(input logic [31:0] c, input bit s);
    return s ? {{96{c[31]}}, c} : {96'b0, c};
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      for (int l = 0; l < 2; l++) begin
        m_pv[d][l] = 1'b0;     m_pval[d][l] = '0;  m_sum[d][l] = '0;
        m_cnt[d][l] = 0;       m_win[d][l] = 0;    m_ovf[d][l] = 1'b0;
        m_racc[d][l] = '0;     m_rvalid[d][l] = 1'b0; m_rovf[d][l] = 1'b0;
      end
    end
  endtask

  // One clock edge of the model: a window collects win products (len, or 1 if
  // len is 0, fixed when the window opens); its running total is clamped to
  // the representable range and the result is published on the last product.
  task automatic modelStep(input bit iclr, input int ilen, input bit iv1, input logic [31:0] ic1,
                           input bit iv2, input logic [31:0] ic2);
    logic signed [127:0] one = 128'sd1;
    logic signed [127:0] maxv, minv;
    bit                  iv;
    logic [31:0]         ic;
    for (int d = 0; d < 3; d++) begin
      maxv = cfg_s[d] ? (one <<< (cfg_w[d] - 1)) - one : (one <<< cfg_w[d]) - one;
      minv = cfg_s[d] ? -(one <<< (cfg_w[d] - 1)) : 128'sd0;
      for (int l = 0; l < 2; l++) begin
        iv = (l == 0) ? iv1 : iv2;
        ic = (l == 0) ? ic1 : ic2;
        m_rvalid[d][l] = 1'b0;
        if (iclr) begin
          m_pv[d][l] = 1'b0; m_cnt[d][l] = 0; m_sum[d][l] = '0; m_ovf[d][l] = 1'b0;
        end else begin
          if (m_pv[d][l]) begin
            if (m_cnt[d][l] == 0) begin
              m_sum[d][l] = m_pval[d][l];
              m_win[d][l] = (ilen == 0) ? 1 : ilen;
            end else begin
              m_sum[d][l] = m_sum[d][l] + m_pval[d][l];
              if (m_sum[d][l] > maxv) begin m_sum[d][l] = maxv; m_ovf[d][l] = 1'b1; end
              if (m_sum[d][l] < minv) begin m_sum[d][l] = minv; m_ovf[d][l] = 1'b1; end
            end
            m_cnt[d][l]++;
            if (m_cnt[d][l] == m_win[d][l]) begin
              m_racc[d][l] = m_sum[d][l]; m_rovf[d][l] = m_ovf[d][l]; m_rvalid[d][l] = 1'b1;
              m_cnt[d][l] = 0; m_ovf[d][l] = 1'b0;
            end
          end
          m_pv[d][l] = iv;
          if (iv) m_pval[d][l] = extendProduct(ic, cfg_s[d]);
        end
      end
    end
  endtask

  task automatic getOut(input int d, input int l, output logic [127:0] acc, output logic vld,
                        output logic ovf, output logic bsy);
    case (d)
      0: begin acc = (l == 0) ? 128'(a_acc1) : 128'(a_acc2); vld = (l == 0) ? a_v1 : a_v2;
               ovf = (l == 0) ? a_o1 : a_o2; bsy = a_busy; end
      1: begin acc = (l == 0) ? 128'(b_acc1) : 128'(b_acc2); vld = (l == 0) ? b_v1 : b_v2;
               ovf = (l == 0) ? b_o1 : b_o2; bsy = b_busy; end
      default: begin acc = (l == 0) ? 128'(c_acc1) : 128'(c_acc2); vld = (l == 0) ? c_v1 : c_v2;
               ovf = (l == 0) ? c_o1 : c_o2; bsy = c_busy; end
    endcase
  endtask

  task automatic compareAll();
    logic [127:0] acc, mask;
    logic         vld, ovf, bsy;
    bit           exp_busy;
    for (int d = 0; d < 3; d++) begin
      mask = (128'd1 << cfg_w[d]) - 128'd1;
      exp_busy = 1'b0;
      for (int l = 0; l < 2; l++) begin
        getOut(d, l, acc, vld, ovf, bsy);
        checkOutput($sformatf("cfg%0d_acc%0d", d, l + 1), acc, m_racc[d][l] & mask);
        checkOutput($sformatf("cfg%0d_acc%0d_valid", d, l + 1), 128'(vld), 128'(m_rvalid[d][l]));
        checkOutput($sformatf("cfg%0d_ovf%0d", d, l + 1), 128'(ovf), 128'(m_rovf[d][l]));
        exp_busy = exp_busy | m_pv[d][l] | (m_cnt[d][l] != 0);
      end
      getOut(d, 0, acc, vld, ovf, bsy);
      checkOutput($sformatf("cfg%0d_busy", d), 128'(bsy), 128'(exp_busy));
    end
  endtask

  // Continuous compare: inputs are stable around every rising edge, outputs
  // are checked 1 time unit after each edge or asynchronous reset assertion.
  initial begin : compare_proc
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep(clr, int'(len), v1, c1, v2, c2);
      #1;
      compareAll();
    end
  end

  task automatic applyStimulus(input logic iclr, input logic [7:0] ilen, input logic iv1,
                               input logic [31:0] ic1, input logic iv2, input logic [31:0] ic2);
    @(negedge clk);
    clr = iclr; len = ilen; v1 = iv1; c1 = ic1; v2 = iv2; c2 = ic2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, len, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main_proc
    repeat (3) @(negedge clk);
    checkOutput("reset_acc1", 128'(a_acc1), 128'd0);
    checkOutput("reset_busy", 128'(a_busy), 128'd0);
    rst_n = 1'b1;
    idle(2);

    // Lane 1 four-product window
    applyStimulus(0, 8'd4, 1, 32'd10, 0, 0);
    applyStimulus(0, 8'd4, 1, 32'd20, 0, 0);
    applyStimulus(0, 8'd4, 1, 32'd30, 0, 0);
    applyStimulus(0, 8'd4, 1, 32'd40, 0, 0);
    idle(1);
    checkOutput("t1_valid_early", 128'(a_v1), 128'd0);
    idle(1);
    checkOutput("t1_acc1", 128'(a_acc1), 128'd100);
    checkOutput("t1_model_acc1", m_racc[0][0], 128'd100);
    checkOutput("t1_valid", 128'(a_v1), 128'd1);
    checkOutput("t1_ovf", 128'(a_o1), 128'd0);
    checkOutput("t1_acc2_valid", 128'(a_v2), 128'd0);
    idle(1);
    checkOutput("t1_pulse_end", 128'(a_v1), 128'd0);

    // Single-product windows with len=1 and len=0
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, (k == 0) ? 8'd1 : 8'd0, 1, 32'hFFFF_FFFF, 0, 0);
      applyStimulus(0, len, 1, 32'd5, 0, 0);
      idle(1);
      checkOutput($sformatf("t2_%0d_acc1_m1", k), 128'(a_acc1), 128'hFF_FFFF_FFFF);
      checkOutput($sformatf("t2_%0d_b_acc1_m1", k), 128'(b_acc1), 128'h1_FFFF_FFFF);
      checkOutput($sformatf("t2_%0d_c_acc1", k), 128'(c_acc1), 128'h0_FFFF_FFFF);
      checkOutput($sformatf("t2_%0d_valid_a", k), 128'(a_v1), 128'd1);
      idle(1);
      checkOutput($sformatf("t2_%0d_acc1_5", k), 128'(a_acc1), 128'd5);
      checkOutput($sformatf("t2_%0d_valid_b", k), 128'(a_v1), 128'd1);
      idle(2);
    end

    // Saturation at both rails in the 33-bit signed build, then recovery
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'd3, 1, 32'h7FFF_FFFF, 1, 32'h8000_0000);
    applyStimulus(0, 8'd1, 1, 32'd1, 0, 0);
    idle(1);
    checkOutput("t3_b_acc1_sat", 128'(b_acc1), 128'h0_FFFF_FFFF);
    checkOutput("t3_b_ovf1", 128'(b_o1), 128'd1);
    checkOutput("t3_b_acc2_sat", 128'(b_acc2), 128'h1_0000_0000);
    checkOutput("t3_b_ovf2", 128'(b_o2), 128'd1);
    checkOutput("t3_a_acc1", 128'(a_acc1), 128'h1_7FFF_FFFD);
    checkOutput("t3_a_ovf1", 128'(a_o1), 128'd0);
    idle(1);
    checkOutput("t3_b_acc1_next", 128'(b_acc1), 128'd1);
    checkOutput("t3_b_ovf1_next", 128'(b_o1), 128'd0);
    idle(2);

    // Unsigned clamp in the 33-bit unsigned build
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'd3, 1, 32'hFFFF_FFFF, 0, 0);
    idle(2);
    checkOutput("t3b_c_acc1_sat", 128'(c_acc1), 128'h1_FFFF_FFFF);
    checkOutput("t3b_c_ovf1", 128'(c_o1), 128'd1);
    checkOutput("t3b_a_acc1", 128'(a_acc1), 128'hFF_FFFF_FFFD);
    idle(2);

    // Independent lanes with gaps; len changed after lane 2's window opened
    applyStimulus(0, 8'd3, 1, 32'd1, 1, 32'd7);
    applyStimulus(0, 8'd3, 1, 32'd2, 0, 0);
    applyStimulus(0, 8'd5, 1, 32'd3, 0, 0);
    applyStimulus(0, 8'd5, 0, 32'd0, 1, 32'd7);
    idle(1);
    checkOutput("t4_acc1", 128'(a_acc1), 128'd6);
    checkOutput("t4_acc1_valid", 128'(a_v1), 128'd1);
    checkOutput("t4_busy_mid", 128'(a_busy), 128'd1);
    applyStimulus(0, 8'd5, 0, 32'd0, 1, 32'd7);
    idle(2);
    checkOutput("t4_acc2", 128'(a_acc2), 128'd21);
    checkOutput("t4_model_acc2", m_racc[0][1], 128'd21);
    checkOutput("t4_acc2_valid", 128'(a_v2), 128'd1);
    idle(2);

    // Clear mid-window colliding with a valid product
    applyStimulus(0, 8'd4, 1, 32'd11, 0, 0);
    applyStimulus(0, 8'd4, 1, 32'd12, 0, 0);
    applyStimulus(1, 8'd4, 1, 32'd13, 0, 0);
    idle(1);
    checkOutput("t5_busy", 128'(a_busy), 128'd0);
    checkOutput("t5_valid", 128'(a_v1), 128'd0);
    checkOutput("t5_acc1_kept", 128'(a_acc1), 128'd6);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 8'd4, 1, 32'(i), 0, 0);
    idle(2);
    checkOutput("t5_acc1_fresh", 128'(a_acc1), 128'd10);
    checkOutput("t5_valid_fresh", 128'(a_v1), 128'd1);
    applyStimulus(0, 8'd1, 1, 32'd9, 0, 0);
    applyStimulus(1, 8'd1, 0, 32'd0, 0, 0);
    idle(1);
    checkOutput("t5_suppressed", 128'(a_v1), 128'd0);
    checkOutput("t5_acc1_after_supp", 128'(a_acc1), 128'd10);
    idle(2);

    // Asynchronous reset between edges mid-window
    applyStimulus(0, 8'd4, 1, 32'd21, 1, 32'd22);
    applyStimulus(0, 8'd4, 1, 32'd23, 0, 0);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_acc1_zero", 128'(a_acc1), 128'd0);
    checkOutput("t6_ovf_b_zero", 128'(b_o2), 128'd0);
    checkOutput("t6_busy_zero", 128'(a_busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'd2, 1, 32'd3, 0, 0);
    applyStimulus(0, 8'd2, 1, 32'd4, 0, 0);
    idle(2);
    checkOutput("t6_acc1", 128'(a_acc1), 128'd7);
    checkOutput("t6_valid", 128'(a_v1), 128'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
